// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_HOLD : keep q, so and bit_cnt unchanged
//   MODE_SHL  : shift toward the MSB, si enters at bit 0
//   MODE_SHR  : shift toward the LSB, si enters at the MSB
//   MODE_LOAD : parallel load from pi and abort the current frame
package shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_bit_cnt.sv
// Frame counter for the universal shift register.
// Counts shifts from 0 to WIDTH-1. The shift that arrives while the count
// is WIDTH-1 wraps the count to 0 and raises done for exactly one cycle.
// Ports:
//   clk   : rising-edge clock
//   clear : synchronous active-high reset, highest priority
//   inc   : one shift happens on this edge
//   zero  : discard the partial frame (parallel load); wins over inc
//   cnt   : shifts completed in the current frame
//   done  : registered one-cycle pulse after the last shift of a frame
module shift_bit_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             zero,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    // done is only ever a single-cycle pulse, so it defaults low.
    done_d = 1'b0;
    if (zero) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left, shift right, parallel load.
// Ports:
//   clk        : rising-edge clock
//   clear      : synchronous active-high reset, beats en and mode
//   en         : clock enable; low freezes q, so and bit_cnt
//   mode       : MODE_HOLD / MODE_SHL / MODE_SHR / MODE_LOAD
//   si         : serial input bit
//   pi         : parallel load data
//   so         : registered bit shifted out by the most recent shift
//   po         : the register contents, no extra stage
//   bit_cnt    : shifts completed in the current frame
//   frame_done : one-cycle pulse after the WIDTH-th shift of a frame
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si,
  input  logic [WIDTH-1:0] pi,
  output logic             so,
  output logic [WIDTH-1:0] po,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             do_shift;
  logic             do_load;

  always_comb begin
    q_d      = q_q;
    so_d     = so_q;
    do_shift = 1'b0;
    do_load  = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], si};
          so_d     = q_q[WIDTH-1];
          do_shift = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {si, q_q[WIDTH-1:1]};
          so_d     = q_q[0];
          do_shift = 1'b1;
        end
        MODE_LOAD: begin
          // so keeps the last shifted-out bit; a load shifts nothing out.
          q_d     = pi;
          do_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q  <= '0;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  shift_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (do_shift),
    .zero  (do_load),
    .cnt   (bit_cnt),
    .done  (frame_done)
  );

  assign so = so_q;
  assign po = q_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg with three instances: WIDTH 4, 8 and 2.
// Each driver step applies inputs, waits for the rising edge and queues the
// hand-computed post-edge outputs {so, po, bit_cnt, frame_done}; a monitor
// per instance pops and compares on the falling edge.
module tb_univ_shift_reg;
  import shift_pkg::*;

  // clock / reset block
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: WIDTH=4
  logic       clear_a, en_a, si_a, so_a, fd_a;
  logic [1:0] mode_a, cnt_a;
  logic [3:0] pi_a, po_a;
  univ_shift_reg #(.WIDTH(4)) dut_a (
    .clk(clk), .clear(clear_a), .en(en_a), .mode(mode_a), .si(si_a), .pi(pi_a),
    .so(so_a), .po(po_a), .bit_cnt(cnt_a), .frame_done(fd_a)
  );

  // instance B: WIDTH=8
  logic       clear_b, en_b, si_b, so_b, fd_b;
  logic [1:0] mode_b;
  logic [2:0] cnt_b;
  logic [7:0] pi_b, po_b;
  univ_shift_reg #(.WIDTH(8)) dut_b (
    .clk(clk), .clear(clear_b), .en(en_b), .mode(mode_b), .si(si_b), .pi(pi_b),
    .so(so_b), .po(po_b), .bit_cnt(cnt_b), .frame_done(fd_b)
  );

  // instance C: WIDTH=2
  logic       clear_c, en_c, si_c, so_c, fd_c;
  logic [1:0] mode_c;
  logic [0:0] cnt_c;
  logic [1:0] pi_c, po_c;
  univ_shift_reg #(.WIDTH(2)) dut_c (
    .clk(clk), .clear(clear_c), .en(en_c), .mode(mode_c), .si(si_c), .pi(pi_c),
    .so(so_c), .po(po_c), .bit_cnt(cnt_c), .frame_done(fd_c)
  );

  // scoreboard queues: {so, po, bit_cnt, frame_done}
  logic [7:0]  exp_a_q[$];
  logic [12:0] exp_b_q[$];
  logic [4:0]  exp_c_q[$];
  string nm_a_q[$], nm_b_q[$], nm_c_q[$];

  // driver tasks
  task automatic a_step(input logic clr, input logic e, input logic [1:0] md,
                        input logic s, input logic [3:0] p,
                        input logic [7:0] exp, input string nm);
    clear_a = clr; en_a = e; mode_a = md; si_a = s; pi_a = p;
    @(posedge clk);
    #1;
    exp_a_q.push_back(exp);
    nm_a_q.push_back(nm);
  endtask

  task automatic b_step(input logic clr, input logic e, input logic [1:0] md,
                        input logic s, input logic [12:0] exp, input string nm);
    clear_b = clr; en_b = e; mode_b = md; si_b = s; pi_b = 8'h00;
    @(posedge clk);
    #1;
    exp_b_q.push_back(exp);
    nm_b_q.push_back(nm);
  endtask

  task automatic c_step(input logic clr, input logic e, input logic [1:0] md,
                        input logic s, input logic [4:0] exp, input string nm);
    clear_c = clr; en_c = e; mode_c = md; si_c = s; pi_c = 2'b00;
    @(posedge clk);
    #1;
    exp_c_q.push_back(exp);
    nm_c_q.push_back(nm);
  endtask

  // monitors
  always @(negedge clk) begin
    if (exp_a_q.size() > 0) begin
      logic [7:0] e, g;
      string      nm;
      e  = exp_a_q.pop_front();
      nm = nm_a_q.pop_front();
      g  = {so_a, po_a, cnt_a, fd_a};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL w4 %s: got so=%b po=%b cnt=%0d fd=%b, expected so=%b po=%b cnt=%0d fd=%b",
                 nm, g[7], g[6:3], g[2:1], g[0], e[7], e[6:3], e[2:1], e[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (exp_b_q.size() > 0) begin
      logic [12:0] e, g;
      string       nm;
      e  = exp_b_q.pop_front();
      nm = nm_b_q.pop_front();
      g  = {so_b, po_b, cnt_b, fd_b};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL w8 %s: got so=%b po=%b cnt=%0d fd=%b, expected so=%b po=%b cnt=%0d fd=%b",
                 nm, g[12], g[11:4], g[3:1], g[0], e[12], e[11:4], e[3:1], e[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (exp_c_q.size() > 0) begin
      logic [4:0] e, g;
      string      nm;
      e  = exp_c_q.pop_front();
      nm = nm_c_q.pop_front();
      g  = {so_c, po_c, cnt_c, fd_c};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL w2 %s: got so=%b po=%b cnt=%0d fd=%b, expected so=%b po=%b cnt=%0d fd=%b",
                 nm, g[4], g[3:2], g[1], g[0], e[4], e[3:2], e[1], e[0]);
      end
    end
  end

  // stimulus
  initial begin
    clear_a = 1'b0; en_a = 1'b0; mode_a = MODE_HOLD; si_a = 1'b0; pi_a = '0;
    clear_b = 1'b0; en_b = 1'b0; mode_b = MODE_HOLD; si_b = 1'b0; pi_b = '0;
    clear_c = 1'b0; en_c = 1'b0; mode_c = MODE_HOLD; si_c = 1'b0; pi_c = '0;

    // WIDTH=4: serial-in left, then drain through so
    a_step(1, 0, MODE_HOLD, 0, 4'h0, {1'b0, 4'b0000, 2'd0, 1'b0}, "reset");
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0001, 2'd1, 1'b0}, "shl_e1");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b0, 4'b0010, 2'd2, 1'b0}, "shl_e2");
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0101, 2'd3, 1'b0}, "shl_e3");
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b1011, 2'd0, 1'b1}, "shl_e4_frame");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b0110, 2'd1, 1'b0}, "drain_e5");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b0, 4'b1100, 2'd2, 1'b0}, "drain_e6");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b1000, 2'd3, 1'b0}, "drain_e7");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b0000, 2'd0, 1'b1}, "drain_e8");

    // WIDTH=4: load 1001 then shift right out
    a_step(0, 1, MODE_LOAD, 0, 4'b1001, {1'b1, 4'b1001, 2'd0, 1'b0}, "load_1001");
    a_step(0, 1, MODE_SHR,  0, 4'h0, {1'b1, 4'b0100, 2'd1, 1'b0}, "shr_1");
    a_step(0, 1, MODE_SHR,  0, 4'h0, {1'b0, 4'b0010, 2'd2, 1'b0}, "shr_2");
    a_step(0, 1, MODE_SHR,  0, 4'h0, {1'b0, 4'b0001, 2'd3, 1'b0}, "shr_3");
    a_step(0, 1, MODE_SHR,  0, 4'h0, {1'b1, 4'b0000, 2'd0, 1'b1}, "shr_4_frame");
    a_step(0, 1, MODE_HOLD, 1, 4'hF, {1'b1, 4'b0000, 2'd0, 1'b0}, "hold");

    // WIDTH=4: load aborts a partial frame
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0001, 2'd1, 1'b0}, "part_1");
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0011, 2'd2, 1'b0}, "part_2");
    a_step(0, 1, MODE_LOAD, 0, 4'hF, {1'b0, 4'b1111, 2'd0, 1'b0}, "abort_load");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b1110, 2'd1, 1'b0}, "after_load_1");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b1100, 2'd2, 1'b0}, "after_load_2");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b1000, 2'd3, 1'b0}, "after_load_3");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b0000, 2'd0, 1'b1}, "after_load_4");

    // WIDTH=4: clear mid-frame at bit_cnt=3, then restart and reverse
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0001, 2'd1, 1'b0}, "pre_clr_1");
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0011, 2'd2, 1'b0}, "pre_clr_2");
    a_step(0, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0111, 2'd3, 1'b0}, "pre_clr_3");
    a_step(1, 1, MODE_SHL,  1, 4'h0, {1'b0, 4'b0000, 2'd0, 1'b0}, "clr_mid_frame");
    a_step(0, 1, MODE_SHR,  1, 4'h0, {1'b0, 4'b1000, 2'd1, 1'b0}, "first_after_clr");
    a_step(0, 0, MODE_SHL,  1, 4'h0, {1'b0, 4'b1000, 2'd1, 1'b0}, "en_low");
    a_step(0, 1, MODE_SHL,  0, 4'h0, {1'b1, 4'b0000, 2'd2, 1'b0}, "reverse_dir");

    // WIDTH=8: enable gap freezes the count
    b_step(1, 0, MODE_HOLD, 0, {1'b0, 8'h00, 3'd0, 1'b0}, "reset");
    b_step(0, 1, MODE_SHL,  1, {1'b0, 8'b00000001, 3'd1, 1'b0}, "shl_1");
    b_step(0, 1, MODE_SHL,  1, {1'b0, 8'b00000011, 3'd2, 1'b0}, "shl_2");
    b_step(0, 1, MODE_SHL,  0, {1'b0, 8'b00000110, 3'd3, 1'b0}, "shl_3");
    for (int i = 0; i < 5; i++)
      b_step(0, 0, MODE_SHL, 1, {1'b0, 8'b00000110, 3'd3, 1'b0}, "en_low_frozen");
    b_step(0, 1, MODE_SHL,  0, {1'b0, 8'b00001100, 3'd4, 1'b0}, "shl_4");
    b_step(0, 1, MODE_SHL,  0, {1'b0, 8'b00011000, 3'd5, 1'b0}, "shl_5");
    b_step(0, 1, MODE_SHL,  0, {1'b0, 8'b00110000, 3'd6, 1'b0}, "shl_6");
    b_step(0, 1, MODE_SHL,  0, {1'b0, 8'b01100000, 3'd7, 1'b0}, "shl_7");
    b_step(0, 1, MODE_SHL,  0, {1'b0, 8'b11000000, 3'd0, 1'b1}, "shl_8_frame");
    b_step(0, 1, MODE_SHL,  0, {1'b1, 8'b10000000, 3'd1, 1'b0}, "shl_9");

    // WIDTH=2: back-to-back frames
    c_step(1, 0, MODE_HOLD, 0, {1'b0, 2'b00, 1'd0, 1'b0}, "reset");
    c_step(0, 1, MODE_SHL,  1, {1'b0, 2'b01, 1'd1, 1'b0}, "e1");
    c_step(0, 1, MODE_SHL,  1, {1'b0, 2'b11, 1'd0, 1'b1}, "e2");
    c_step(0, 1, MODE_SHL,  0, {1'b1, 2'b10, 1'd1, 1'b0}, "e3");
    c_step(0, 1, MODE_SHL,  1, {1'b1, 2'b01, 1'd0, 1'b1}, "e4");
    c_step(0, 1, MODE_SHL,  0, {1'b0, 2'b10, 1'd1, 1'b0}, "e5");
    c_step(0, 1, MODE_SHL,  0, {1'b1, 2'b00, 1'd0, 1'b1}, "e6");
    c_step(0, 1, MODE_SHL,  1, {1'b0, 2'b01, 1'd1, 1'b0}, "e7");
    c_step(0, 1, MODE_SHL,  0, {1'b0, 2'b10, 1'd0, 1'b1}, "e8");

    // let the monitors drain, then report
    repeat (3) @(posedge clk);
    if (exp_a_q.size() + exp_b_q.size() + exp_c_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0",
               exp_a_q.size() + exp_b_q.size() + exp_c_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
